// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states, default parameters and a constant log2 helper
package dmem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_LATENCY = 4;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-enabled synchronous write and enabled synchronous read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DW = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      i_we,
  input  logic                      i_re,
  input  logic [clog2(DEPTH)-1:0]   i_idx,
  input  logic [DW/8-1:0]           i_be,
  input  logic [DW-1:0]             i_wdata,
  output logic [DW-1:0]             o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (i_we && i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_idx];
  end
endmodule

// File: rtl/data_memory_lat.sv
// data_memory_lat: latency-configurable data memory with req/ack handshake,
// byte-enabled writes and alignment/range error reporting
module data_memory_lat
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [31:0]             addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  output logic [DATA_WIDTH-1:0]   r_data_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    busy_o
);
  localparam int BPW = DATA_WIDTH / 8;
  localparam int LSB = clog2(BPW);
  localparam int IW = clog2(DEPTH);
  localparam int CW = clog2(LATENCY + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_we, r_err, r_zero;
  logic [BPW-1:0] r_be;
  logic [IW-1:0] r_idx;
  logic [DATA_WIDTH-1:0] r_wdata, w_rdata;
  logic w_accept, w_done, w_err;
  assign w_accept = (r_state == ST_IDLE) && req_i;
  assign w_done = r_state == ST_DONE;
  assign w_err = ((addr_i & 32'(BPW - 1)) != 32'd0) || ((addr_i >> (LSB + IW)) != 32'd0);
  assign busy_o = r_state != ST_IDLE;
  // r_zero forces the visible read data to 0 after reset or an error ack
  assign r_data_o = r_zero ? '0 : w_rdata;
  always_comb
    w_next = r_state == ST_IDLE ? (req_i ? (LATENCY > 1 ? ST_WAIT : ST_DONE) : ST_IDLE) :
             r_state == ST_WAIT ? (r_cnt == CW'(1) ? ST_DONE : ST_WAIT) : ST_IDLE;
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      r_cnt <= '0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      r_zero <= 1'b1;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_be <= '0;
      r_idx <= '0;
      r_wdata <= '0;
    end else begin
      ack_o <= w_done;
      err_o <= w_done && r_err;
      if (w_done) r_zero <= r_err ? 1'b1 : (r_we ? r_zero : 1'b0);
      if (w_accept) begin
        r_cnt <= CW'(LATENCY - 1);
        r_we <= we_i;
        r_err <= w_err;
        r_be <= be_i;
        r_idx <= addr_i[LSB +: IW];
        r_wdata <= w_data_i;
      end else if (r_state == ST_WAIT) r_cnt <= r_cnt - CW'(1);
    end
  dmem_array #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .i_we(w_done && r_we && !r_err),
    .i_re(w_done && !r_we && !r_err),
    .i_idx(r_idx),
    .i_be(r_be),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );
endmodule
